// File: rtl/led_value_display_pkg.sv
// Shared definitions for the LED value display: segment codes, FSM states, BCD helpers.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package led_value_display_pkg;

  // Active-low segment codes, bit order {dp,g,f,e,d,c,b,a}; dp is always off.
  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_MINUS = 8'hBF;

  // Shift counter width and number of shift cycles per conversion.
  localparam int SHIFT_W     = 3;
  localparam int SHIFT_COUNT = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    COMMIT  = 2'd2
  } dispState_t;

  function automatic logic [7:0] segDecode(input logic [3:0] digit);
    logic [7:0] code;
    case (digit)
      4'd0:    code = SEG_0;
      4'd1:    code = SEG_1;
      4'd2:    code = SEG_2;
      4'd3:    code = SEG_3;
      4'd4:    code = SEG_4;
      4'd5:    code = SEG_5;
      4'd6:    code = SEG_6;
      4'd7:    code = SEG_7;
      4'd8:    code = SEG_8;
      4'd9:    code = SEG_9;
      default: code = SEG_BLANK;
    endcase
    return code;
  endfunction

  // Double-dabble correction: any nibble >= 5 gets +3 before the next shift.
  function automatic logic [11:0] dabbleAdjust(input logic [11:0] bcd);
    logic [11:0] adj;
    adj = bcd;
    for (int n = 0; n < 3; n++) begin
      if (adj[n*4 +: 4] >= 4'd5) adj[n*4 +: 4] = adj[n*4 +: 4] + 4'd3;
    end
    return adj;
  endfunction

endpackage

// File: rtl/led_value_display_bcd.sv
// Serial binary-to-BCD converter (double-dabble) for a 9-bit magnitude.
// Latency: 8 shift cycles after start; done pulses during the last shift cycle.
// Backpressure: start is ignored while busy; result holds until the next start.
//   clk, rstN          clock / async active-low reset
//   start, magnitude   load request and 9-bit value to convert
//   busy, done         conversion running / last shift cycle in progress
//   hundreds/tens/units BCD result nibbles
module bin_to_bcd_serial
  import led_value_display_pkg::*;
(
  input  logic       clk,
  input  logic       rstN,
  input  logic       start,
  input  logic [8:0] magnitude,
  output logic       busy,
  output logic       done,
  output logic [3:0] hundreds,
  output logic [3:0] tens,
  output logic [3:0] units
);

  logic [SHIFT_W-1:0] shiftCnt;
  logic [7:0]         shReg;
  logic [11:0]        bcd;

  assign done     = busy && (shiftCnt == SHIFT_W'(SHIFT_COUNT - 1));
  assign hundreds = bcd[11:8];
  assign tens     = bcd[7:4];
  assign units    = bcd[3:0];

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      shiftCnt <= '0;
      shReg    <= '0;
      bcd      <= '0;
      busy     <= 1'b0;
    end else if (start && !busy) begin
      // Bit 8 would only ever be shifted into an all-zero BCD field with no
      // correction, so it is preloaded into the units LSB; the remaining
      // eight bits then need exactly eight shift cycles.
      shReg    <= magnitude[7:0];
      bcd      <= {11'd0, magnitude[8]};
      shiftCnt <= '0;
      busy     <= 1'b1;
    end else if (busy) begin
      {bcd, shReg} <= {dabbleAdjust(bcd), shReg} << 1;
      shiftCnt     <= shiftCnt + SHIFT_W'(1);
      if (done) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/led_value_display.sv
// Shows an 8-bit value (unsigned or two's complement) in decimal on a 4-digit common-anode display.
// Latency: 9 cycles from captured change to new display digits; refresh every REFRESH_DIV cycles/digit.
// Backpressure: input changes during a conversion are held off; re-detected when back in IDLE.
//   Clock, Reset   clock / async active-low reset
//   iData, iSigned value to show and its signedness
//   oAnode         active-low digit enables (bit0 = rightmost)
//   oSegment       active-low {dp,g,f,e,d,c,b,a}
//   oBusy          conversion in progress
module led_value_display
  import led_value_display_pkg::*;
#(
  parameter int REFRESH_DIV = 50000,
  parameter int REFRESH_W   = 16
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [7:0] iData,
  input  logic       iSigned,
  output logic [3:0] oAnode,
  output logic [7:0] oSegment,
  output logic       oBusy
);

  dispState_t state, stateNext;

  logic [8:0] inVal;
  logic [8:0] captured;
  logic [8:0] magnitude;
  logic       isNeg;
  logic       start;
  logic       signWork;

  logic       bcdBusy, bcdDone;
  logic [3:0] bcdHund, bcdTens, bcdUnits;

  logic [3:0] dispHund, dispTens, dispUnits;
  logic       dispSign;

  logic [REFRESH_W-1:0] refCnt;
  logic [1:0]           digitIdx;
  logic [7:0]           segSel;

  always_comb begin
    inVal     = {iSigned, iData};
    isNeg     = iSigned & iData[7];
    // Two's-complement negate widened to 9 bits so 8'h80 yields 128.
    magnitude = isNeg ? ({1'b0, ~iData} + 9'd1) : {1'b0, iData};
    start     = (state == IDLE) && (inVal != captured) && !bcdBusy;
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (start) stateNext = CONVERT;
      CONVERT: if (bcdDone) stateNext = COMMIT;
      COMMIT:  stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state     <= IDLE;
      captured  <= '0;
      signWork  <= 1'b0;
      dispHund  <= '0;
      dispTens  <= '0;
      dispUnits <= '0;
      dispSign  <= 1'b0;
    end else begin
      state <= stateNext;
      if (start) begin
        captured <= inVal;
        signWork <= isNeg;
      end
      // Display only changes here, so the old value stays up during conversion.
      if (state == COMMIT) begin
        dispHund  <= bcdHund;
        dispTens  <= bcdTens;
        dispUnits <= bcdUnits;
        dispSign  <= signWork;
      end
    end
  end

  assign oBusy = (state != IDLE);

  bin_to_bcd_serial uBcd (
    .clk       (Clock),
    .rstN      (Reset),
    .start     (start),
    .magnitude (magnitude),
    .busy      (bcdBusy),
    .done      (bcdDone),
    .hundreds  (bcdHund),
    .tens      (bcdTens),
    .units     (bcdUnits)
  );

  // Free-running refresh: advances the digit index on each counter wrap.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      refCnt   <= '0;
      digitIdx <= '0;
    end else if (refCnt == REFRESH_W'(REFRESH_DIV - 1)) begin
      refCnt   <= '0;
      digitIdx <= digitIdx + 2'd1;
    end else begin
      refCnt <= refCnt + REFRESH_W'(1);
    end
  end

  // Leading-zero blanking: tens blank only if hundreds is also zero.
  always_comb begin
    segSel = SEG_BLANK;
    case (digitIdx)
      2'd0: segSel = segDecode(dispUnits);
      2'd1: if ((dispHund != 4'd0) || (dispTens != 4'd0)) segSel = segDecode(dispTens);
      2'd2: if (dispHund != 4'd0) segSel = segDecode(dispHund);
      default: if (dispSign) segSel = SEG_MINUS;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      oAnode   <= 4'b1110;
      oSegment <= SEG_0;
    end else begin
      oAnode   <= ~(4'b0001 << digitIdx);
      oSegment <= segSel;
    end
  end

endmodule

// File: doc/led_value_display.md
Name: led_value_display

Overview:
Downstream consumer of the ALU's 8-bit LED output register. Watches the 8-bit value and converts it serially to decimal (BCD) whenever it changes, then drives a 4-digit multiplexed common-anode 7-segment display. This lets programs that use the LED instruction show results in decimal on the board display. Unsigned mode shows 0..255; signed mode shows -128..127.

Parameters:
REFRESH_DIV, 50000, clock cycles per displayed digit before advancing to the next anode (minimum 2).
REFRESH_W, 16, width of the refresh counter; must satisfy 2^REFRESH_W >= REFRESH_DIV.

Ports:
Clock  input  1  system clock, all state on rising edge
Reset  input  1  asynchronous, active-low reset
iData  input  8  value to display (ALU LED output register)
iSigned  input  1  1 = interpret iData as two's complement
oAnode  output  4  digit enables, active-low, bit0 = rightmost digit
oSegment  output  8  segments {dp,g,f,e,d,c,b,a}, active-low; dp always off (1)
oBusy  output  1  high while a conversion is in progress

Behaviour:
- Reset (Reset=0, async): state IDLE; captured value {iSigned,iData} register = 9'h000; BCD digits = 0,0,0; sign = 0; refresh counter = 0; digit index = 0; oAnode = 4'b1110; oSegment = 8'hC0 ('0'); oBusy = 0.
- Change detect: in IDLE, if {iSigned,iData} != captured, capture on that edge (cycle c) and go to CONVERT.
- Magnitude: unsigned mode uses iData. Signed mode with iData[7]=1 uses the 9-bit magnitude -iData (8'h80 gives 128) and sets sign = 1.
- CONVERT: serial double-dabble over 8 shift cycles (c+1..c+8). In each cycle, add 3 to any BCD nibble >= 5, then shift left one bit with the magnitude MSB entering.
- COMMIT: at cycle c+9, copy the working BCD digits and the sign into the display registers and return to IDLE.
- Display registers change only in COMMIT; the old value stays displayed during conversion.
- oBusy = 1 from cycle c+1 through c+9 inclusive, otherwise 0.
- New digits appear on oSegment no later than the first refresh slot after c+9.
- Input change during CONVERT/COMMIT: ignored until IDLE. The next IDLE cycle detects the mismatch and starts a new conversion, so the display always converges to the last stable input.
- Refresh: counter runs 0..REFRESH_DIV-1 continuously, independent of conversion. On wrap, digit index advances 0→1→2→3→0.
- oAnode is a registered one-cold decode of the digit index. oSegment is registered and aligned with oAnode (same edge).
- Digit content:
  - digit0: always the units digit, never blanked.
  - digit1 and digit2: blank (8'hFF) while they and all more-significant digits are zero.
  - digit3: minus (8'hBF) when sign = 1, else blank.
- Segment codes, active-low:
  - 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90
  - blank=FF, minus=BF
- Reset mid-conversion: aborts immediately to reset values. After reset release, the first IDLE cycle reconverts if the input is nonzero.

Decomposition:
- Shared definitions include file, alongside the existing definitions file, holds:
  - segment code constants (digits 0-9, blank, minus);
  - state encodings IDLE, CONVERT, COMMIT;
  - a shift-count width constant.
- One natural sub-module, bin_to_bcd_serial: start/busy/done handshake, 9-bit magnitude in, three BCD nibbles out, 8 shift cycles plus a done pulse.
- The top level owns change detection, sign handling, blanking, refresh and segment encoding.

Test Plan (REFRESH_DIV=4):
1. Reset low then high with iData=0 → oAnode=1110, oSegment=C0, oBusy=0. oAnode then cycles 1110,1101,1011,0111,1110 every 4 cycles; digits 1-3 show FF.
2. iData=255, iSigned=0 → oBusy high exactly 9 cycles. Then digit3=FF, digit2=A4, digit1=92, digit0=92.
3. iData=8'h80, iSigned=1 → digit3=BF, digit2=F9, digit1=A4, digit0=80. Then toggle iSigned to 0 → reconversion, digit3=FF, digits 1,2,8 (F9,A4,80).
4. iData=7 → digit3..1=FF, digit0=F8. Then iData=0 → digit0=C0, others FF.
5. iData=12, change to 34 three cycles into CONVERT → 12 commits first, then a second oBusy period. Final display FF,FF,B0,99.
6. Reset asserted during CONVERT (after iData=200) → outputs at reset values the same cycle. After release, reconversion yields FF,A4,C0,C0.
